// File: rtl/mem_rresp_pkg.sv
// Shared memory-subsystem definitions for the read responder and its buffer.
// Holds the FSM encoding, the default entry count and word-address helpers.
package mem_rresp_pkg;

  localparam int RBUF_ENTRIES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } rresp_state_e;

  // Two byte addresses refer to the same 32-bit word.
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return ((a ^ b) & 32'hFFFF_FFFC) == 32'h0;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/rbuf_array.sv
// Direct-mapped word buffer: tag/valid arrays with combinational lookup,
// byte-lane data storage with store merge, line fill and a registered read port.
module rbuf_array
  import mem_rresp_pkg::*;
#(
  parameter int ENTRIES = RBUF_ENTRIES_DEFAULT,
  localparam int IW = $clog2(ENTRIES),
  localparam int TW = 30 - IW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [IW-1:0] rd_idx,
  input  logic [TW-1:0] rd_tag,
  output logic          rd_hit,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  input  logic [IW-1:0] wr_idx,
  input  logic [TW-1:0] wr_tag,
  input  logic          wr_en,
  input  logic [3:0]    wr_strb,
  input  logic [31:0]   wr_data,
  input  logic          fill_en,
  input  logic [IW-1:0] fill_idx,
  input  logic [TW-1:0] fill_tag,
  input  logic [31:0]   fill_data,
  input  logic          fill_valid,
  input  logic          inval
);

  logic [ENTRIES-1:0] valid_reg;
  logic [TW-1:0]      tag_mem [ENTRIES];
  logic               wr_hit;
  logic               merge_en;

  assign rd_hit   = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign wr_hit   = valid_reg[wr_idx] && (tag_mem[wr_idx] == wr_tag);
  assign merge_en = wr_en && wr_hit;

  always_ff @(posedge CLK) begin
    if (fill_en) tag_mem[fill_idx] <= fill_tag;
  end

  // Invalidate wins over a coincident fill.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         valid_reg <= '0;
    else if (inval)   valid_reg <= '0;
    else if (fill_en) valid_reg[fill_idx] <= fill_valid;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [ENTRIES];
      logic [7:0] rd_byte_reg;

      // A fill to the same entry overrides a coincident merge.
      always_ff @(posedge CLK) begin
        if (merge_en && wr_strb[gi]) lane_mem[wr_idx] <= wr_data[8*gi +: 8];
        if (fill_en) lane_mem[fill_idx] <= fill_data[8*gi +: 8];
      end

      // Read-before-write: a same-cycle merge is not visible in this capture.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST)         rd_byte_reg <= '0;
        else if (fill_en) rd_byte_reg <= fill_data[8*gi +: 8];
        else if (rd_en)   rd_byte_reg <= lane_mem[rd_idx];
      end

      assign rd_data[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

endmodule

// File: rtl/mem_rresp.sv
// Read responder for the mread stage: single-word direct-mapped buffer in front
// of a backing bus, with store snooping, flush and fence invalidate.
module mem_rresp
  import mem_rresp_pkg::*;
#(
  parameter int ENTRIES = RBUF_ENTRIES_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        INVALIDATE,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RIADDR,
  output logic [31:0] DATA_ROADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  output logic        DATA_RBUSY,
  input  logic        DATA_WREN,
  input  logic [31:0] DATA_WADDR,
  input  logic [3:0]  DATA_WSTRB,
  input  logic [31:0] DATA_WDATA,
  output logic        MEM_RREQ,
  output logic [31:0] MEM_RADDR,
  input  logic        MEM_RACK,
  input  logic [31:0] MEM_RDATA
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;

  rresp_state_e state_reg, state_next;
  logic [31:0]  req_addr_reg, req_addr_next;
  logic [31:0]  resp_addr_reg, resp_addr_next;
  logic         resp_valid_reg, resp_valid_next;
  logic         mem_rreq_reg, mem_rreq_next;
  logic         kill_reg, kill_next;
  logic         flush_pend_reg, flush_pend_next;
  logic         started_reg;

  logic         rd_hit;
  logic         accept;
  logic         ack;
  logic         wr_match_req;
  logic         fill_valid;
  logic [31:0]  rd_data;

  assign accept       = DATA_RDEN && (state_reg != REQ);
  assign ack          = (state_reg == REQ) && MEM_RACK;
  assign wr_match_req = DATA_WREN && same_word(DATA_WADDR, req_addr_reg);
  // A store to the word being fetched makes the fetched copy stale.
  assign fill_valid   = !(kill_reg || wr_match_req || INVALIDATE);

  rbuf_array #(.ENTRIES(ENTRIES)) u_array (
    .CLK        (CLK),
    .RST        (RST),
    .rd_idx     (DATA_RIADDR[IW+1:2]),
    .rd_tag     (DATA_RIADDR[31:IW+2]),
    .rd_hit     (rd_hit),
    .rd_en      (accept && rd_hit),
    .rd_data    (rd_data),
    .wr_idx     (DATA_WADDR[IW+1:2]),
    .wr_tag     (DATA_WADDR[31:IW+2]),
    .wr_en      (DATA_WREN),
    .wr_strb    (DATA_WSTRB),
    .wr_data    (DATA_WDATA),
    .fill_en    (ack),
    .fill_idx   (req_addr_reg[IW+1:2]),
    .fill_tag   (req_addr_reg[31:IW+2]),
    .fill_data  (MEM_RDATA),
    .fill_valid (fill_valid),
    .inval      (INVALIDATE)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= IDLE;
      req_addr_reg   <= '0;
      resp_addr_reg  <= '0;
      resp_valid_reg <= 1'b0;
      mem_rreq_reg   <= 1'b0;
      kill_reg       <= 1'b0;
      flush_pend_reg <= 1'b0;
      started_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      req_addr_reg   <= req_addr_next;
      resp_addr_reg  <= resp_addr_next;
      resp_valid_reg <= resp_valid_next;
      mem_rreq_reg   <= mem_rreq_next;
      kill_reg       <= kill_next;
      flush_pend_reg <= flush_pend_next;
      started_reg    <= 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    req_addr_next   = req_addr_reg;
    resp_addr_next  = '0;
    resp_valid_next = 1'b0;
    mem_rreq_next   = mem_rreq_reg;
    kill_next       = kill_reg;
    flush_pend_next = flush_pend_reg;
    case (state_reg)
      REQ: begin
        if (FLUSH)        flush_pend_next = 1'b1;
        if (wr_match_req) kill_next = 1'b1;
        if (MEM_RACK) begin
          mem_rreq_next   = 1'b0;
          kill_next       = 1'b0;
          flush_pend_next = 1'b0;
          if (flush_pend_reg || FLUSH) begin
            state_next = IDLE;
          end else begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_addr_next  = req_addr_reg;
          end
        end
      end
      default: begin
        state_next = IDLE;
        if (DATA_RDEN) begin
          if (rd_hit) begin
            resp_valid_next = 1'b1;
            resp_addr_next  = DATA_RIADDR;
          end else begin
            state_next      = REQ;
            req_addr_next   = DATA_RIADDR;
            mem_rreq_next   = 1'b1;
            kill_next       = DATA_WREN && same_word(DATA_WADDR, DATA_RIADDR);
            flush_pend_next = 1'b0;
          end
        end
      end
    endcase
  end

  // Busy is masked on the first cycle out of reset.
  assign DATA_RBUSY  = started_reg && ((state_reg == REQ) || (accept && !rd_hit));
  assign DATA_RVALID = resp_valid_reg && !FLUSH;
  assign DATA_RDATA  = DATA_RVALID ? rd_data : 32'h0;
  assign DATA_ROADDR = DATA_RVALID ? resp_addr_reg : 32'h0;
  assign MEM_RREQ    = mem_rreq_reg;
  assign MEM_RADDR   = word_align(req_addr_reg);

endmodule

// File: doc/mem_rresp.md
MEM_RRESP -- requirements
Module: mem_rresp

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameter SHALL be: ENTRIES, 4, number of direct-mapped word entries (power of two, minimum 2).
REQ-003 Ports SHALL be, in order:
 - CLK  in  1  clock
 - RST  in  1  asynchronous active-low reset
 - FLUSH  in  1  kill pending response
 - INVALIDATE  in  1  clear all entries (fence)
 - DATA_RDEN  in  1  read request from the mread stage
 - DATA_RIADDR  in  32  read address
 - DATA_ROADDR  out  32  address of the returned data
 - DATA_RVALID  out  1  response valid
 - DATA_RDATA  out  32  response word, unaligned and unextended
 - DATA_RBUSY  out  1  responder cannot accept a request; feeds core stall
 - DATA_WREN  in  1  store snoop from the write stage
 - DATA_WADDR  in  32  store address
 - DATA_WSTRB  in  4  store byte enables
 - DATA_WDATA  in  32  store data
 - MEM_RREQ  out  1  backing-bus read request
 - MEM_RADDR  out  32  backing-bus word address
 - MEM_RACK  in  1  backing-bus acknowledge, with data valid
 - MEM_RDATA  in  32  backing-bus data

Function
REQ-004 Addresses SHALL be word-granular: index = addr[log2(ENTRIES)+1:2]; tag = addr[31:log2(ENTRIES)+2]; addr[1:0] ignored for lookup.
REQ-005 The FSM SHALL have three states: IDLE, REQ and RESP.
REQ-006 When DATA_RDEN is high in IDLE or RESP and the lookup hits, the block SHALL stay in or enter IDLE and drive the following on the next cycle for exactly one cycle:
 - DATA_RVALID=1
 - DATA_RDATA = entry word
 - DATA_ROADDR = DATA_RIADDR as sampled
REQ-007 When DATA_RDEN is high in IDLE or RESP and the lookup misses, the block SHALL latch the address and enter REQ.
REQ-008 In REQ, the block SHALL hold MEM_RREQ=1, hold MEM_RADDR={addr[31:2],2'b00} stable, and keep DATA_RBUSY=1 until MEM_RACK is sampled high.
REQ-009 When MEM_RACK is sampled high, the block SHALL write MEM_RDATA into the entry, set the entry valid and tag, and enter RESP.
REQ-010 In RESP, the block SHALL drive DATA_RVALID=1, DATA_RDATA = captured word and DATA_ROADDR = latched address for one cycle, with DATA_RBUSY=0; the next state is IDLE unless REQ-006 or REQ-007 applies.
REQ-011 DATA_RDEN while DATA_RBUSY=1 SHALL be ignored.
REQ-012 DATA_RBUSY SHALL be combinational: 1 in REQ, and also in the cycle a miss is detected.
REQ-013 Miss-to-response latency SHALL be ack cycle + 1; hit latency SHALL be exactly 1.
REQ-014 On a DATA_WREN whose address hits a valid entry, the block SHALL merge the DATA_WSTRB-selected bytes of DATA_WDATA into that entry at the next edge.
REQ-015 If DATA_WREN and a hit read target the same word in one cycle, the response SHALL return the pre-write word.
REQ-016 If DATA_WREN matches the in-flight REQ address at any cycle before or with the ack, the fill SHALL leave the entry invalid; the response still returns MEM_RDATA.
REQ-017 FLUSH in REQ SHALL NOT abandon the bus transaction: the fill completes and the FSM returns to IDLE without RESP.
REQ-018 FLUSH in RESP, or in a hit response cycle, SHALL force DATA_RVALID=0.
REQ-019 INVALIDATE SHALL clear all valid bits at the next edge.
REQ-020 If INVALIDATE coincides with an ack, the filled entry SHALL also end invalid.
REQ-021 When DATA_RVALID=0, DATA_RDATA and DATA_ROADDR SHALL be 0.

Reset
REQ-022 RST low SHALL asynchronously force: state IDLE; all valid bits 0; MEM_RREQ, MEM_RADDR, DATA_RVALID, DATA_RDATA and DATA_ROADDR to 0.
REQ-023 DATA_RBUSY SHALL be 0 during reset and on the first cycle after release; entry data need not be reset.
REQ-024 Reset asserted mid-REQ SHALL drop MEM_RREQ immediately; the backing bus tolerates an abandoned request.

Structure
REQ-025 The FSM state encoding (IDLE=2'd0, REQ=2'd1, RESP=2'd2) and the default entry count SHALL live in the shared memory-subsystem package.
REQ-026 The storage array, with tag/valid arrays and byte-merge write, SHALL be one sub-module named rbuf_array; the FSM and snoop logic SHALL stay in mem_rresp.

Verification
REQ-027 Cold miss: RDEN, addr 0x0000_1004 -> MEM_RREQ=1 with MEM_RADDR=0x0000_1004; RBUSY=1 until ack with 0xDEAD_BEEF; next cycle RVALID=1, RDATA=0xDEAD_BEEF, ROADDR=0x0000_1004.
REQ-028 Hit after fill: RDEN, 0x0000_1006 -> next cycle RVALID=1, RDATA=0xDEAD_BEEF, no MEM_RREQ.
REQ-029 Snoop merge: WREN 0x0000_1004, WSTRB=0011, WDATA=0x0000_1234, then RDEN same word -> RDATA=0xDEAD_1234.
REQ-030 Conflict eviction: fill 0x0000_1004, then read 0x0000_1014 (same index, ENTRIES=4) -> new fill; rereading 0x0000_1004 misses.
REQ-031 FLUSH during REQ with ack delayed 3 cycles -> no RVALID; a subsequent read of the same word hits.
REQ-032 RST low mid-REQ -> MEM_RREQ=0 within the same cycle; after release, RDEN of a previously filled word misses.
